// File: rtl/mult_fu_pkg.sv
// Shared machine definitions, then the pipeline types used by the multiplier FU.
package sys_defs;
  localparam int PRN_SIZE = 64;
  localparam int ROB_SIZE = 32;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'h00,
    ALU_SUB  = 5'h01,
    ALU_AND  = 5'h02,
    ALU_OR   = 5'h03,
    ALU_XOR  = 5'h04,
    ALU_SLL  = 5'h05,
    ALU_SRL  = 5'h06,
    ALU_SRA  = 5'h07,
    ALU_MULQ = 5'h08
  } ALU_FUNC;
endpackage

package mult_fu_pkg;
  import sys_defs::*;

  localparam int XLEN  = 64;
  localparam int TAG_W = $clog2(PRN_SIZE);
  localparam int ROB_W = $clog2(ROB_SIZE);

  // One pipeline slot: running multiply state plus the tags that ride along.
  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  mcand;
    logic [XLEN-1:0]  mplier;
    logic [XLEN-1:0]  sum;
    logic [TAG_W-1:0] tag;
    logic [ROB_W-1:0] rob;
  } stage_t;
endpackage

// File: rtl/mult_fu_if.sv
// Issue / CDB bundle between the reservation station, the CDB arbiter and the mult FU.
interface mult_fu_if;
  import sys_defs::*;
  import mult_fu_pkg::*;

  logic             fu_valid_in;
  logic [XLEN-1:0]  fu_opa_in;
  logic [XLEN-1:0]  fu_opb_in;
  logic [TAG_W-1:0] fu_dest_tag_in;
  logic [ROB_W-1:0] fu_rob_idx_in;
  ALU_FUNC          fu_alu_func;
  logic             fu_cdb_grant;
  logic             fu_flush;
  logic [XLEN-1:0]  fu_result_out;
  logic [TAG_W-1:0] fu_dest_tag_out;
  logic [ROB_W-1:0] fu_rob_idx_out;
  logic             fu_result_valid;
  logic             mult_available;

  modport master (
    output fu_valid_in, fu_opa_in, fu_opb_in, fu_dest_tag_in, fu_rob_idx_in,
           fu_alu_func, fu_cdb_grant, fu_flush,
    input  fu_result_out, fu_dest_tag_out, fu_rob_idx_out, fu_result_valid,
           mult_available
  );

  modport slave (
    input  fu_valid_in, fu_opa_in, fu_opb_in, fu_dest_tag_in, fu_rob_idx_in,
           fu_alu_func, fu_cdb_grant, fu_flush,
    output fu_result_out, fu_dest_tag_out, fu_rob_idx_out, fu_result_valid,
           mult_available
  );
endinterface

// File: rtl/mult_fu_stage.sv
// One partial-product stage: folds XLEN/NUM_STAGES multiplier bits into the sum.
module mult_stage
  import mult_fu_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   en_i,
  input  logic   flush_i,
  input  stage_t stage_i,
  output stage_t stage_o
);
  localparam int unsigned W = XLEN / NUM_STAGES;

  stage_t stage_d, stage_q;

  // Accumulate this slice's partial product; line up operands for the next slice.
  always_comb begin
    stage_d        = stage_i;
    stage_d.sum    = stage_i.sum + stage_i.mcand * XLEN'(stage_i.mplier[W-1:0]);
    stage_d.mcand  = stage_i.mcand << W;
    stage_d.mplier = stage_i.mplier >> W;
  end

  // Reset clears everything, flush kills only the valid bit, stall holds.
  always_ff @(posedge clock) begin
    if (reset)        stage_q       <= '0;
    else if (flush_i) stage_q.valid <= 1'b0;
    else if (en_i)    stage_q       <= stage_d;
  end

  assign stage_o = stage_q;
endmodule

// File: rtl/mult_fu.sv
// Pipelined 64x64 -> low-64 unsigned multiplier FU with CDB back-pressure and flush.
module mult_fu
  import sys_defs::*;
  import mult_fu_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4
) (
  input  logic       clock,
  input  logic       reset,
  mult_fu_if.slave   fu
);
  stage_t                  issue_s;
  stage_t [NUM_STAGES-1:0] pipe;
  stage_t                  tail;
  logic                    stall;
  logic [2*XLEN-1:0]       unused_tail;

  assign tail  = pipe[NUM_STAGES-1];
  // Whole pipe freezes while the output slot waits for a CDB grant.
  assign stall = tail.valid & ~fu.fu_cdb_grant;

  // Issue slot; non-MULQ functions never enter the pipe.
  always_comb begin
    issue_s        = '0;
    issue_s.valid  = fu.fu_valid_in & ~stall & (fu.fu_alu_func == ALU_MULQ);
    issue_s.mcand  = fu.fu_opa_in;
    issue_s.mplier = fu.fu_opb_in;
    issue_s.tag    = fu.fu_dest_tag_in;
    issue_s.rob    = fu.fu_rob_idx_in;
  end

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      mult_stage #(.NUM_STAGES(NUM_STAGES)) u_stage (
        .clock   (clock),
        .reset   (reset),
        .en_i    (~stall),
        .flush_i (fu.fu_flush),
        .stage_i (issue_s),
        .stage_o (pipe[gi])
      );
    end else begin : g_rest
      mult_stage #(.NUM_STAGES(NUM_STAGES)) u_stage (
        .clock   (clock),
        .reset   (reset),
        .en_i    (~stall),
        .flush_i (fu.fu_flush),
        .stage_i (pipe[gi-1]),
        .stage_o (pipe[gi])
      );
    end
  end

  assign fu.fu_result_valid = tail.valid;
  assign fu.fu_result_out   = tail.valid ? tail.sum : '0;
  assign fu.fu_dest_tag_out = tail.tag;
  assign fu.fu_rob_idx_out  = tail.rob;
  assign fu.mult_available  = ~stall;

  // Operands are fully shifted out by the last stage.
  assign unused_tail = {tail.mcand, tail.mplier};
endmodule
